sta_result_collector: RTL
=========================

// Module: sta_result_collector
// PURPOSE
//   Downstream of the STA core. Captures one STA result stream (worst_delay plus
//   the path-node sequence, valid for N consecutive cycles) into a local buffer.
//   Replays it to a backpressured consumer as framed 8-bit beats.
//   Decouples the core's fixed-rate output from a slower host/tester readout.
// PARAMETERS
//   DEPTH     16  max path nodes stored (1..16); cnt width = $clog2(DEPTH+1)
//   SRC_NODE  0   expected first path node (used only with STA_PATH_CHECK_EN)
//   DST_NODE  1   expected last path node (used only with STA_PATH_CHECK_EN)
// PORTS
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   in_valid     in   1  STA core out_valid; high = one path node this cycle
//   worst_delay  in   8  STA worst_delay; sampled on first in_valid cycle only
//   path         in   4  STA path node for this cycle
//   out_valid    out  1  beat available on out_data
//   out_data     out  8  framed beat (see BEHAVIOUR)
//   out_last     out  1  high on final beat of a frame
//   out_ready    in   1  consumer accepts beat when out_valid & out_ready
//   busy         out  1  state != IDLE
//   overrun      out  1  sticky: in_valid seen while draining; cleared by reset only
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, idx=0; out_valid=0, out_data=0, out_last=0, busy=0,
//     overrun=0. Reset asserted mid-operation clears everything immediately;
//     a partial frame is discarded, never resumed.
//   IDLE: in_valid=1 -> wd_r<=worst_delay, buf[0]<=path, cnt<=1, trunc<=0 -> COLLECT.
//   COLLECT: in_valid=1 & cnt<DEPTH -> buf[cnt]<=path, cnt++.
//     in_valid=1 & cnt==DEPTH -> node dropped, trunc<=1, cnt saturates.
//     in_valid=0 -> HDR_WD. Any 1-cycle gap ends the stream.
//   HDR_WD: out_valid=1, out_data=wd_r; on ready -> HDR_LEN.
//   HDR_LEN: out_data={trunc, err, 1'b0, cnt[4:0]}; on ready -> NODES, idx<=0.
//   NODES: out_data={4'b0, buf[idx]}; out_last=(idx==cnt-1).
//     ready & !last -> idx++. ready & last -> IDLE.
//   Latency: first out_valid is the cycle after in_valid is first sampled low.
//     Minimum frame time = cnt+2 cycles with out_ready held high.
//   out_valid/out_data/out_last are decoded from registered state only and are
//     stable while out_valid & !out_ready. No combinational in->out path.
//   in_valid in HDR_WD/HDR_LEN/NODES: data ignored, overrun<=1, drain unaffected.
//   Back-to-back: a frame can be captured the cycle after IDLE is re-entered.
//   Width rules: cnt 5 bits (max 16); header len field = stored count, not the
//     received count, when trunc=1.
// CONFIGURATION
//   STA_PATH_CHECK_EN defined: err is set when any of these holds:
//     buf[0]!=SRC_NODE; last stored node!=DST_NODE; any node repeats
//     (16-bit seen mask, cleared at IDLE capture). Result appears in header bit6.
//   Undefined: err tied 0, header bit6 always 0, no mask/compare logic built.
// STRUCTURE
//   sta_pkg: node_t (logic[3:0]), delay_t (logic[7:0]),
//     state enum {IDLE,COLLECT,HDR_WD,HDR_LEN,NODES}, HDR_TRUNC_BIT=7, HDR_ERR_BIT=6.
//   Sub-module sta_path_buf: DEPTH x 4 register file, 1 write port, 1 async read
//     port; no reset on storage (contents qualified by cnt).
//   FSM, counters and framing mux stay in this module.
// TESTING
//   1 Path 0,5,1, wd=42, ready=1 -> beats 42, 0x03, 0x00, 0x05, 0x01.
//     out_last on 0x01; out_valid rises the cycle after in_valid falls.
//   2 Same stimulus, out_ready toggling 1010.. -> identical beats, each held
//     stable until accepted, no duplicates or drops.
//   3 18-node stream, DEPTH=16 -> header 0x90, exactly first 16 nodes, then IDLE.
//   4 1-cycle in_valid during NODES -> overrun=1 until reset; frame unchanged.
//   5 rst_n low mid-NODES -> out_valid=0 immediately; next stream 0,1 gives
//     a clean frame wd, 0x02, 0x00, 0x01.
//   6 STA_PATH_CHECK_EN: path 2,3,3,1 -> header 0x44; path 0,1 -> header 0x02.

Source files
------------

// File: rtl/sta_result_collector_pkg.sv
// Shared types and constants for the STA result collector.
//   node_t        : one STA path node id (4 bits)
//   delay_t       : STA worst-delay value (8 bits)
//   state_e       : collector FSM states
//   HDR_TRUNC_BIT : header bit set when the stream held more nodes than the buffer
//   HDR_ERR_BIT   : header bit carrying the optional path-check result
//   idx_width()   : address width for a buffer of the given depth (at least 1 bit)
package sta_result_collector_pkg;

    typedef logic [3:0] node_t;
    typedef logic [7:0] delay_t;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StHdrWd,
        StHdrLen,
        StNodes
    } state_e;

    localparam int unsigned HDR_TRUNC_BIT = 7;
    localparam int unsigned HDR_ERR_BIT   = 6;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sta_result_collector_if.sv
// Stream interface of the STA result collector.
//   in_valid/worst_delay/path : STA core result stream (one node per valid cycle)
//   out_valid/out_data/out_last/out_ready : framed 8-bit beats to the consumer
// Modports:
//   master : the collector (consumes the STA stream, produces beats)
//   slave  : the environment (drives the STA stream, accepts beats)
interface sta_result_collector_if;
    import sta_result_collector_pkg::*;

    logic   in_valid;
    delay_t worst_delay;
    node_t  path;
    logic   out_valid;
    delay_t out_data;
    logic   out_last;
    logic   out_ready;

    modport master (
        input  in_valid, worst_delay, path, out_ready,
        output out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, worst_delay, path, out_ready,
        input  out_valid, out_data, out_last
    );

endinterface

// File: rtl/sta_result_collector_path_buf.sv
// Path-node storage for the result collector: DEPTH x 4-bit register file with one
// synchronous write port and one asynchronous read port. Storage is not reset;
// the owner qualifies contents with its node count.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : node written
//   raddr : read address
//   rdata : node stored at raddr
module sta_result_collector_path_buf
    import sta_result_collector_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  node_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output node_t            rdata
);

    node_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sta_result_collector.sv
// Captures one STA result stream (worst delay + path nodes) and replays it as a
// frame of 8-bit beats: worst delay, header {trunc, err, 0, len[4:0]}, then one
// beat per stored node. Outputs decode from registered state only.
// Optional feature macro: STA_PATH_CHECK_EN (endpoint and repeated-node check
// reported in header bit 6; without it that bit is always 0).
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : stream interface (master modport)
//   busy    : FSM not idle
//   overrun : sticky, a stream arrived while a frame was draining
module sta_result_collector
    import sta_result_collector_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SRC_NODE = 0,
    parameter int unsigned DST_NODE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sta_result_collector_if.master        bus,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = idx_width(DEPTH);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    delay_t          wd_q, wd_d;
    logic            trunc_q, trunc_d;
    logic            overrun_q, overrun_d;

    logic            buf_we;
    logic [IdxW-1:0] buf_waddr;
    node_t           buf_rdata;
    logic            err;
    logic            last_node;
    delay_t          hdr;

    sta_result_collector_path_buf #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_path_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (bus.path),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

    assign last_node = (CntW'(idx_q) == cnt_q - CntW'(1));

    always_comb begin
        hdr                = '0;
        hdr[HDR_TRUNC_BIT] = trunc_q;
        hdr[HDR_ERR_BIT]   = err;
        hdr[4:0]           = 5'(cnt_q);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        wd_d          = wd_q;
        trunc_d       = trunc_q;
        overrun_d     = overrun_q;
        buf_we        = 1'b0;
        buf_waddr     = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    wd_d    = bus.worst_delay;
                    buf_we  = 1'b1;
                    cnt_d   = CntW'(1);
                    trunc_d = 1'b0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (bus.in_valid) begin
                    if (cnt_q < CntW'(DEPTH)) begin
                        buf_we    = 1'b1;
                        buf_waddr = IdxW'(cnt_q);
                        cnt_d     = cnt_q + CntW'(1);
                    end else begin
                        // Buffer full: drop the node, keep the count saturated.
                        trunc_d = 1'b1;
                    end
                end else begin
                    state_d = StHdrWd;
                end
            end
            StHdrWd: begin
                bus.out_valid = 1'b1;
                bus.out_data  = wd_q;
                if (bus.out_ready) begin
                    state_d = StHdrLen;
                end
            end
            StHdrLen: begin
                bus.out_valid = 1'b1;
                bus.out_data  = hdr;
                if (bus.out_ready) begin
                    idx_d   = '0;
                    state_d = StNodes;
                end
            end
            StNodes: begin
                bus.out_valid = 1'b1;
                bus.out_data  = {4'b0, buf_rdata};
                bus.out_last  = last_node;
                if (bus.out_ready) begin
                    if (last_node) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A new stream during drain cannot be captured; flag it and keep draining.
        if (bus.in_valid && (state_q inside {StHdrWd, StHdrLen, StNodes})) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            wd_q      <= '0;
            trunc_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wd_q      <= wd_d;
            trunc_q   <= trunc_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef STA_PATH_CHECK_EN
    logic [15:0] seen_q;
    logic        first_bad_q;
    logic        dup_q;
    node_t       last_q;

    // Track only stored nodes; dropped (truncated) nodes are not checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q      <= '0;
            first_bad_q <= 1'b0;
            dup_q       <= 1'b0;
            last_q      <= '0;
        end else if (buf_we) begin
            if (state_q == StIdle) begin
                seen_q      <= 16'(1) << bus.path;
                first_bad_q <= (bus.path != node_t'(SRC_NODE));
                dup_q       <= 1'b0;
            end else begin
                if (seen_q[bus.path]) begin
                    dup_q <= 1'b1;
                end
                seen_q[bus.path] <= 1'b1;
            end
            last_q <= bus.path;
        end
    end

    assign err = first_bad_q | dup_q | (last_q != node_t'(DST_NODE));
`else
    // Folds to constant 0; only keeps the node parameters referenced.
    assign err = (SRC_NODE == DST_NODE) & 1'b0;
`endif

    assign busy    = (state_q != StIdle);
    assign overrun = overrun_q;

endmodule
